// File: rtl/stall_controller_if.sv
// Bundles the hazard inputs and the hold/flush/PC-enable outputs exchanged
// between the datapath and the stall controller.
interface stall_controller_if #(
  parameter int NREGS = 4,
  parameter int REGW  = 5,
  parameter int CNTW  = 16
);
  logic             ihit;
  logic             dhit;
  logic             dmemreq;
  logic             ex_memread;
  logic [REGW-1:0]  ex_rd;
  logic [REGW-1:0]  id_rs;
  logic [REGW-1:0]  id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             ex_mdu_start;
  logic             ex_branch_taken;
  logic             halt_in;
  logic [NREGS-1:0] stall;
  logic [NREGS-1:0] flush;
  logic             pc_wen;
  logic             mdu_busy;
  logic             halted;
  logic [CNTW-1:0]  stall_cnt;

  // The controller side: consumes hazard information, drives pipeline enables.
  modport master (
    input  ihit, dhit, dmemreq, ex_memread, ex_rd, id_rs, id_rt,
           id_rs_used, id_rt_used, ex_mdu_start, ex_branch_taken, halt_in,
    output stall, flush, pc_wen, mdu_busy, halted, stall_cnt
  );

  // The datapath side: reports hazards, obeys the enables.
  modport slave (
    output ihit, dhit, dmemreq, ex_memread, ex_rd, id_rs, id_rt,
           id_rs_used, id_rt_used, ex_mdu_start, ex_branch_taken, halt_in,
    input  stall, flush, pc_wen, mdu_busy, halted, stall_cnt
  );
endinterface

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: multi-bubble load-use interlock,
// multicycle-execute window, data-memory wait, sticky halt and a saturating
// stall-cycle counter. Outputs are per-latch hold/flush enables and PC write.
module stall_controller #(
  parameter int NREGS      = 4,
  parameter int REGW       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int MDU_LAT    = 4,
  parameter int CNTW       = 16
) (
  input logic               CLK,
  input logic               nRST,
  stall_controller_if.master bus
);

  typedef enum logic [1:0] {RUN, LOADUSE, MDU, HALT} state_t;

  localparam logic [2:0]      LU_INIT  = 3'(LU_BUBBLES - 1);
  localparam logic [3:0]      MDU_INIT = 4'(MDU_LAT - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  state_t           state, next_state;
  logic [2:0]       bcnt, next_bcnt;
  logic [3:0]       mcnt, next_mcnt;
  logic             luhaz, memwait, mdu_active;
  logic [NREGS-1:0] stall, flush;
  logic             pc_wen, mdu_busy, halted;
  logic [CNTW-1:0]  stall_cnt;

  assign luhaz = bus.ex_memread && (bus.ex_rd != REGW'(0)) &&
                 ((bus.id_rs_used && (bus.ex_rd == bus.id_rs)) ||
                  (bus.id_rt_used && (bus.ex_rd == bus.id_rt)));
  assign memwait = bus.dmemreq && !bus.dhit;

  // The multicycle window includes the cycle the op enters EX.
  assign mdu_active = (state == MDU) ||
                      (bus.ex_mdu_start && ((state == RUN) || (state == LOADUSE)));

  // Next state: halt wins even over a memory wait; otherwise a wait freezes everything.
  always_comb begin
    next_state = state;
    next_bcnt  = bcnt;
    next_mcnt  = mcnt;
    if (state != HALT && bus.halt_in) begin
      next_state = HALT;
    end else if (!memwait) begin
      case (state)
        RUN: begin
          if (bus.ex_mdu_start) begin
            next_state = MDU;
            next_mcnt  = MDU_INIT;
          end else if (bus.ex_branch_taken) begin
            next_state = RUN;
          end else if (LU_BUBBLES > 1 && luhaz) begin
            next_state = LOADUSE;
            next_bcnt  = LU_INIT;
          end
        end
        LOADUSE: begin
          if (bus.ex_mdu_start) begin
            next_state = MDU;
            next_mcnt  = MDU_INIT;
          end else if (bus.ex_branch_taken || bcnt <= 3'd1) begin
            next_state = RUN;
          end else begin
            next_bcnt = bcnt - 3'd1;
          end
        end
        MDU: begin
          if (mcnt <= 4'd1) next_state = RUN;
          else              next_mcnt  = mcnt - 4'd1;
        end
        default: next_state = HALT;
      endcase
    end
  end

  // Output enables in strict priority order; reset forces everything quiet.
  always_comb begin
    stall    = '0;
    flush    = '0;
    pc_wen   = 1'b0;
    mdu_busy = 1'b0;
    halted   = 1'b0;
    if (!nRST) begin
      pc_wen = 1'b0;
    end else if (state == HALT) begin
      stall  = '1;
      halted = 1'b1;
    end else begin
      mdu_busy = mdu_active;
      if (memwait) begin
        stall = '1;
      end else if (mdu_active) begin
        stall[1:0] = 2'b11;
        flush[2]   = 1'b1;
      end else if (bus.ex_branch_taken) begin
        flush[1:0] = 2'b11;
        pc_wen     = 1'b1;
      end else if ((luhaz && state == RUN) || state == LOADUSE) begin
        stall[0] = 1'b1;
        flush[1] = 1'b1;
      end else if (!bus.ihit) begin
        flush[0] = 1'b1;
      end else begin
        pc_wen = 1'b1;
      end
    end
  end

  // State, bubble/latency counters and the saturating stall counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      bcnt      <= '0;
      mcnt      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      bcnt  <= next_bcnt;
      mcnt  <= next_mcnt;
      if (!pc_wen && state != HALT && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

  assign bus.stall     = stall;
  assign bus.flush     = flush;
  assign bus.pc_wen    = pc_wen;
  assign bus.mdu_busy  = mdu_busy;
  assign bus.halted    = halted;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_stall_controller.sv
// Directed bench for stall_controller: main instance (LU_BUBBLES=2, MDU_LAT=4,
// CNTW=16) plus a CNTW=4 twin sharing the same inputs for counter saturation.
module tb_stall_controller;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;
  int   busy_cycles;

  stall_controller_if #(.NREGS(4), .REGW(5), .CNTW(16)) bus ();
  stall_controller_if #(.NREGS(4), .REGW(5), .CNTW(4))  sbus ();

  stall_controller #(.NREGS(4), .REGW(5), .LU_BUBBLES(2), .MDU_LAT(4), .CNTW(16))
    dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  stall_controller #(.NREGS(4), .REGW(5), .LU_BUBBLES(2), .MDU_LAT(4), .CNTW(4))
    dut_sat (.CLK(CLK), .nRST(nRST), .bus(sbus));

  assign sbus.ihit            = bus.ihit;
  assign sbus.dhit            = bus.dhit;
  assign sbus.dmemreq         = bus.dmemreq;
  assign sbus.ex_memread      = bus.ex_memread;
  assign sbus.ex_rd           = bus.ex_rd;
  assign sbus.id_rs           = bus.id_rs;
  assign sbus.id_rt           = bus.id_rt;
  assign sbus.id_rs_used      = bus.id_rs_used;
  assign sbus.id_rt_used      = bus.id_rt_used;
  assign sbus.ex_mdu_start    = bus.ex_mdu_start;
  assign sbus.ex_branch_taken = bus.ex_branch_taken;
  assign sbus.halt_in         = bus.halt_in;

  // Expected {stall, flush, pc_wen, mdu_busy, halted} patterns.
  localparam logic [10:0] ZERO  = 11'b0000_0000_0_0_0;
  localparam logic [10:0] IDLE  = 11'b0000_0000_1_0_0;
  localparam logic [10:0] LU    = 11'b0001_0010_0_0_0;
  localparam logic [10:0] MDUO  = 11'b0011_0100_0_1_0;
  localparam logic [10:0] FULL  = 11'b1111_0000_0_0_0;
  localparam logic [10:0] FULLM = 11'b1111_0000_0_1_0;
  localparam logic [10:0] BR    = 11'b0000_0011_1_0_0;
  localparam logic [10:0] FETCH = 11'b0000_0001_0_0_0;
  localparam logic [10:0] HLT   = 11'b1111_0000_0_0_1;

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [10:0] ctl();
    return {bus.stall, bus.flush, bus.pc_wen, bus.mdu_busy, bus.halted};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ihit, input logic dmemreq, input logic dhit,
                               input logic memread, input logic [4:0] rd,
                               input logic [4:0] rs, input logic rs_used,
                               input logic [4:0] rt, input logic rt_used,
                               input logic mdu_start, input logic branch, input logic halt);
    bus.ihit            = ihit;
    bus.dmemreq         = dmemreq;
    bus.dhit            = dhit;
    bus.ex_memread      = memread;
    bus.ex_rd           = rd;
    bus.id_rs           = rs;
    bus.id_rs_used      = rs_used;
    bus.id_rt           = rt;
    bus.id_rt_used      = rt_used;
    bus.ex_mdu_start    = mdu_start;
    bus.ex_branch_taken = branch;
    bus.halt_in         = halt;
  endtask

  task automatic idle();
    applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One cycle: outputs sampled at the falling edge, then advance past the rising edge.
  task automatic cycle_check(input string tag, input logic [10:0] exp);
    @(negedge CLK);
    checkOutput(tag, 32'(ctl()), 32'(exp));
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    idle();

    // Reset: outputs quiet, counter cleared.
    cycle_check("rst_out", ZERO);
    cycle_check("rst_out2", ZERO);
    checkOutput("rst_cnt", 32'(bus.stall_cnt), 0);
    nRST = 1'b1;
    cycle_check("run_idle", IDLE);

    // No hazard when ex_rd is r0 or the matching source is unused.
    applyStimulus(1, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0);
    cycle_check("lu_r0", IDLE);
    applyStimulus(1, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 0, 0, 0, 0);
    cycle_check("lu_unused", IDLE);
    checkOutput("cnt_nohaz", 32'(bus.stall_cnt), 0);

    // Load-use with two bubbles.
    applyStimulus(1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 0);
    cycle_check("lu_b1", LU);
    idle();
    cycle_check("lu_b2", LU);
    cycle_check("lu_done", IDLE);
    checkOutput("cnt_lu", 32'(bus.stall_cnt), 2);

    // Multicycle op: four busy cycles.
    applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    cycle_check("mdu_c1", MDUO);
    idle();
    for (int i = 0; i < 3; i++) cycle_check("mdu_cn", MDUO);
    cycle_check("mdu_done", IDLE);
    checkOutput("cnt_mdu", 32'(bus.stall_cnt), 6);

    // Memory wait inside the multicycle window stretches it to seven cycles.
    busy_cycles = 0;
    applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    @(negedge CLK);
    if (bus.mdu_busy) busy_cycles++;
    checkOutput("mw_start", 32'(ctl()), 32'(MDUO));
    tick();
    applyStimulus(1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (bus.mdu_busy) busy_cycles++;
      checkOutput("mw_wait", 32'(ctl()), 32'(FULLM));
      tick();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (!bus.mdu_busy) break;
      busy_cycles++;
      checkOutput("mw_resume", 32'(ctl()), 32'(MDUO));
      tick();
    end
    checkOutput("mw_after", 32'(ctl()), 32'(IDLE));
    tick();
    checkOutput("mw_busy_total", 32'(busy_cycles), 7);
    checkOutput("cnt_mw", 32'(bus.stall_cnt), 13);

    // Branch beats load-use and leaves the state in RUN.
    applyStimulus(1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 0);
    cycle_check("br_lu", BR);
    idle();
    cycle_check("br_lu_run", IDLE);

    // Branch with memory wait: full stall until dhit, then the branch flush.
    applyStimulus(1, 1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 0);
    cycle_check("br_mw1", FULL);
    cycle_check("br_mw2", FULL);
    applyStimulus(1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 0);
    cycle_check("br_mw_hit", BR);
    idle();
    cycle_check("br_mw_run", IDLE);
    checkOutput("cnt_br", 32'(bus.stall_cnt), 15);

    // Branch arriving while a load-use bubble is pending.
    applyStimulus(1, 0, 0, 1, 5'd9, 5'd0, 0, 5'd9, 1, 0, 0, 0);
    cycle_check("lurt_b1", LU);
    applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
    cycle_check("lu_br", BR);
    idle();
    cycle_check("lu_br_run", IDLE);

    // Fetch miss bubbles only IF/ID.
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    cycle_check("fetch_miss", FETCH);
    checkOutput("cnt_fetch", 32'(bus.stall_cnt), 17);

    // Halt during memory wait, then sticky under random inputs.
    applyStimulus(1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    cycle_check("halt_mw", FULL);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      cycle_check("halt_sticky", HLT);
    end
    checkOutput("cnt_halt", 32'(bus.stall_cnt), 18);
    nRST = 1'b0;
    cycle_check("halt_rst", ZERO);
    checkOutput("cnt_halt_rst", 32'(bus.stall_cnt), 0);
    nRST = 1'b1;
    idle();
    cycle_check("halt_cleared", IDLE);

    // Saturation: the 4-bit twin stops at 15 while the main counter reaches 20.
    applyStimulus(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      tick();
      if (i == 9) checkOutput("sat_mid", 32'(sbus.stall_cnt), 10);
    end
    checkOutput("sat_cap", 32'(sbus.stall_cnt), 15);
    checkOutput("sat_main", 32'(bus.stall_cnt), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
